// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - DVI TMDS 8b/10b channel encoder, 2-cycle pipeline.
// Optional disparity monitor ports enabled by TMDS_DISPARITY_MON_EN.
module tmds_channel_encoder #(
   parameter int INVERT_OUT = 0,
   parameter int CNT_W      = 5
) (
   input  logic             pixclk,
   input  logic             reset,
   input  logic             de,
   input  logic             c0,
   input  logic             c1,
   input  logic [7:0]       d,
`ifdef TMDS_DISPARITY_MON_EN
   output logic [CNT_W-1:0] disparity,
   output logic             disp_err,
`endif
   output logic [9:0]       tmds
);

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;
   localparam logic [9:0] RST_SYM = (INVERT_OUT != 0) ? ~CTRL_00 : CTRL_00;
   localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);

   logic [3:0]  n1d;
   logic        use_xnor;
   logic        acc;
   logic [8:0]  qm_next;

   logic        de_q;
   logic [1:0]  c_q;
   logic [8:0]  q_m;

   logic [3:0]  n1;
   logic signed [CNT_W-1:0] bal;
   logic signed [CNT_W-1:0] cnt;
   logic signed [CNT_W-1:0] cnt_nx;
   logic [9:0]  sym;
   logic        q8;
   logic        cnt_pos;
   logic        cnt_neg;

   always_comb begin
      n1d = 4'd0;
      for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
      acc = d[0];
      qm_next = 9'd0;
      qm_next[0] = acc;
      for (int i = 1; i < 8; i++) begin
         acc = use_xnor ? ~(acc ^ d[i]) : (acc ^ d[i]);
         qm_next[i] = acc;
      end
      qm_next[8] = ~use_xnor;
   end

   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         de_q <= 1'b0;
         c_q  <= 2'b00;
         q_m  <= 9'd0;
      end else begin
         de_q <= de;
         c_q  <= {c1, c0};
         q_m  <= qm_next;
      end
   end

   // bal is n1-n0 of q_m[7:0]; always even, within -8..+8
   always_comb begin
      n1 = 4'd0;
      for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, q_m[i]};
      bal     = CNT_W'(2 * int'(n1) - 8);
      q8      = q_m[8];
      cnt_neg = cnt[CNT_W-1];
      cnt_pos = !cnt_neg && (cnt != '0);
      sym     = CTRL_00;
      cnt_nx  = cnt;
      if (!de_q) begin
         cnt_nx = '0;
         case (c_q)
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
         endcase
      end else if ((cnt == '0) || (n1 == 4'd4)) begin
         sym    = {~q8, q8, q8 ? q_m[7:0] : ~q_m[7:0]};
         cnt_nx = q8 ? (cnt + bal) : (cnt - bal);
      end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
         sym    = {1'b1, q8, ~q_m[7:0]};
         cnt_nx = cnt + (q8 ? TWO : '0) - bal;
      end else begin
         sym    = {1'b0, q8, q_m[7:0]};
         cnt_nx = cnt - (q8 ? '0 : TWO) + bal;
      end
   end

   // Inversion only touches the line symbol; cnt follows the true symbol
   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         tmds <= RST_SYM;
      end else begin
         cnt  <= cnt_nx;
         tmds <= (INVERT_OUT != 0) ? ~sym : sym;
      end
   end

`ifdef TMDS_DISPARITY_MON_EN
   assign disparity = cnt;

   always_ff @(posedge pixclk or posedge reset) begin
      if (reset) disp_err <= 1'b0;
      else if ((int'(cnt_nx) > 8) || (int'(cnt_nx) < -8)) disp_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - Bench for tmds_channel_encoder against an integer reference model.
module tb_tmds_channel_encoder;

   logic       pixclk = 1'b0;
   logic       reset;
   logic       de, c0, c1;
   logic [7:0] d;
   logic [9:0] tmds, tmds_inv;
`ifdef TMDS_DISPARITY_MON_EN
   logic [4:0] disparity, disparity_inv;
   logic       disp_err, disp_err_inv;
`endif

   always #5 pixclk = ~pixclk;

   tmds_channel_encoder #(.INVERT_OUT(0), .CNT_W(5)) dut (
      .pixclk(pixclk), .reset(reset), .de(de), .c0(c0), .c1(c1), .d(d),
`ifdef TMDS_DISPARITY_MON_EN
      .disparity(disparity), .disp_err(disp_err),
`endif
      .tmds(tmds));

   tmds_channel_encoder #(.INVERT_OUT(1), .CNT_W(5)) dut_inv (
      .pixclk(pixclk), .reset(reset), .de(de), .c0(c0), .c1(c1), .d(d),
`ifdef TMDS_DISPARITY_MON_EN
      .disparity(disparity_inv), .disp_err(disp_err_inv),
`endif
      .tmds(tmds_inv));

   int         total = 0;
   int         bad = 0;
   int         mcnt;
   logic       pde, pc1, pc0;
   logic [7:0] pd;
   logic [9:0] exp_sym;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      mcnt = 0;
      pde = 1'b0; pc1 = 1'b0; pc0 = 1'b0; pd = 8'h00;
      exp_sym = 10'h354;
   endtask

   // Encodes the word sampled one edge earlier, with integer disparity
   task automatic model_edge();
      int  ones_d, ones_q, diff;
      bit  xn, q, q8;
      logic [7:0] qm;
      if (!pde) begin
         mcnt = 0;
         case ({pc1, pc0})
            2'b00:   exp_sym = 10'h354;
            2'b01:   exp_sym = 10'h0AB;
            2'b10:   exp_sym = 10'h154;
            default: exp_sym = 10'h2AB;
         endcase
      end else begin
         ones_d = $countones(pd);
         xn = (ones_d > 4) || (ones_d == 4 && pd[0] == 1'b0);
         q = pd[0];
         qm[0] = q;
         for (int i = 1; i < 8; i++) begin
            q = xn ? !(q ^ pd[i]) : (q ^ pd[i]);
            qm[i] = q;
         end
         q8 = !xn;
         ones_q = $countones(qm);
         diff = ones_q - (8 - ones_q);
         if (mcnt == 0 || diff == 0) begin
            exp_sym = {~q8, q8, q8 ? qm : ~qm};
            mcnt = mcnt + (q8 ? diff : -diff);
         end else if ((mcnt > 0 && diff > 0) || (mcnt < 0 && diff < 0)) begin
            exp_sym = {1'b1, q8, ~qm};
            mcnt = mcnt + 2 * int'(q8) - diff;
         end else begin
            exp_sym = {1'b0, q8, qm};
            mcnt = mcnt - 2 * int'(!q8) + diff;
         end
      end
   endtask

   task automatic step(input logic i_de, input logic i_c1, input logic i_c0, input logic [7:0] i_d);
      de = i_de; c1 = i_c1; c0 = i_c0; d = i_d;
      @(posedge pixclk);
      model_edge();
      pde = i_de; pc1 = i_c1; pc0 = i_c0; pd = i_d;
      @(negedge pixclk);
      chk("sym", tmds, exp_sym);
      chk("sym_inv", tmds_inv, ~exp_sym);
`ifdef TMDS_DISPARITY_MON_EN
      chk_int("disparity", int'($signed(disparity)), mcnt);
      chk_int("disp_range", int'(($signed(disparity) > 5'sd8) || ($signed(disparity) < -5'sd8)), 0);
      chk_int("disp_err", int'(disp_err), 0);
`endif
   endtask

   initial begin
      logic rde;
      int   burst;
      reset = 1'b1; de = 1'b0; c0 = 1'b0; c1 = 1'b0; d = 8'h00;
      model_reset();
      #1;
      chk("rst_async", tmds, 10'h354);
      chk("rst_async_inv", tmds_inv, 10'h0AB);
      repeat (2) @(negedge pixclk);
      chk("rst_hold", tmds, 10'h354);
      reset = 1'b0;

      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("ctl_rel", tmds, 10'h354);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("ctl01", tmds, 10'h0AB);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      chk("ctl10", tmds, 10'h154);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ctl11", tmds, 10'h2AB);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ctl00", tmds, 10'h354);

      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("zero_a", tmds, 10'h100);
      chk("zero_a_inv", tmds_inv, 10'h2FF);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("zero_b", tmds, 10'h3FF);
      chk("zero_b_inv", tmds_inv, 10'h000);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("zero_c", tmds, 10'h100);
      chk("zero_c_inv", tmds_inv, 10'h2FF);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("post_de", tmds, 10'h354);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("restart", tmds, 10'h100);

      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'hFF);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("ones", tmds, 10'h200);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      rde = 1'b0;
      burst = 0;
      for (int i = 0; i < 10000; i++) begin
         if (burst == 0) begin
            burst = int'($urandom_range(1, 40));
            rde = ~rde;
         end
         burst--;
         step(rde, 1'($urandom), 1'($urandom), 8'($urandom));
      end

      step(1'b1, 1'b0, 1'b0, 8'h5A);
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      reset = 1'b1;
      #1;
      chk("mid_rst", tmds, 10'h354);
      chk("mid_rst_inv", tmds_inv, 10'h0AB);
      model_reset();
      @(posedge pixclk);
      @(negedge pixclk);
      chk("mid_rst_hold", tmds, 10'h354);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("no_stale", tmds, 10'h354);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("after_rst", tmds, 10'h100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
